// File: rtl/audio_i2s_master_tx.sv
// rtl/audio_i2s_master_tx.sv - I2S bus master: BCK/LRCK generation and left-justified stereo DAC serializer
// Optional: define AUD_TX_REPEAT_ON_UNDERRUN_EN to resend the last loaded pair on underrun instead of zeros.
module audio_i2s_master_tx #(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 16,
  parameter int BCK_DIV = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iENABLE,
  input  logic [DATA_W-1:0] iSAMPLE_L,
  input  logic [DATA_W-1:0] iSAMPLE_R,
  input  logic              iVALID,
  output logic              oREADY,
  output logic              oAUD_BCK,
  output logic              oAUD_LRCK,
  output logic              oAUD_DATA,
  output logic              oUNDERRUN,
  input  logic              iCLR_UNDERRUN
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int BIT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_W - 1);

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              bck_q, bck_d;
  logic              lrck_q, lrck_d;
  logic              data_q, data_d;
  logic              ready_q, ready_d;
  logic              underrun_q, underrun_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] right_q, right_d;
`ifdef AUD_TX_REPEAT_ON_UNDERRUN_EN
  logic [DATA_W-1:0] last_l_q, last_l_d;
  logic [DATA_W-1:0] last_r_q, last_r_d;
`endif

  logic              do_load;
  logic              underrun_set;
  logic [DATA_W-1:0] load_l;
  logic [DATA_W-1:0] load_r;

  // Source of the next frame: the holding buffer, or the underrun fill pattern.
  always_comb begin
    if (hold_full_q) begin
      load_l = hold_l_q;
      load_r = hold_r_q;
    end else begin
`ifdef AUD_TX_REPEAT_ON_UNDERRUN_EN
      load_l = last_l_q;
      load_r = last_r_q;
`else
      load_l = '0;
      load_r = '0;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    bck_d        = bck_q;
    lrck_d       = lrck_q;
    data_d       = data_q;
    underrun_d   = underrun_q;
    hold_full_d  = hold_full_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    shift_d      = shift_q;
    right_d      = right_q;
`ifdef AUD_TX_REPEAT_ON_UNDERRUN_EN
    last_l_d     = last_l_q;
    last_r_d     = last_r_q;
`endif
    do_load      = 1'b0;
    underrun_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bck_d  = 1'b0;
        lrck_d = 1'b0;
        data_d = 1'b0;
        div_d  = '0;
        bit_d  = '0;
        if (iENABLE) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        do_load = 1'b1;
        div_d   = '0;
        bit_d   = '0;
        bck_d   = 1'b0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          bck_d = ~bck_q;
          // LRCK and DATA move only on the BCK falling edge.
          if (bck_q) begin
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
              if (lrck_q) begin
                lrck_d  = 1'b0;
                data_d  = right_q[DATA_W-1];
                shift_d = right_q << 1;
              end else if (iENABLE) begin
                do_load = 1'b1;
              end else begin
                state_d = ST_IDLE;
                lrck_d  = 1'b0;
                data_d  = 1'b0;
              end
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              data_d  = shift_q[DATA_W-1];
              shift_d = shift_q << 1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_load) begin
      lrck_d  = 1'b1;
      data_d  = load_l[DATA_W-1];
      shift_d = load_l << 1;
      right_d = load_r;
      if (hold_full_q) begin
        hold_full_d = 1'b0;
`ifdef AUD_TX_REPEAT_ON_UNDERRUN_EN
        last_l_d    = hold_l_q;
        last_r_d    = hold_r_q;
`endif
      end else begin
        underrun_set = 1'b1;
      end
    end

    if (iCLR_UNDERRUN) begin
      underrun_d = 1'b0;
    end
    if (underrun_set) begin
      underrun_d = 1'b1;
    end

    // ready_q mirrors an empty buffer, so an accept never collides with a successful load.
    if (iVALID && ready_q) begin
      hold_full_d = 1'b1;
      hold_l_d    = iSAMPLE_L;
      hold_r_d    = iSAMPLE_R;
    end
  end

  assign ready_d = ~hold_full_d;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      bck_q       <= 1'b0;
      lrck_q      <= 1'b0;
      data_q      <= 1'b0;
      ready_q     <= 1'b1;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      shift_q     <= '0;
      right_q     <= '0;
`ifdef AUD_TX_REPEAT_ON_UNDERRUN_EN
      last_l_q    <= '0;
      last_r_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      bck_q       <= bck_d;
      lrck_q      <= lrck_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      shift_q     <= shift_d;
      right_q     <= right_d;
`ifdef AUD_TX_REPEAT_ON_UNDERRUN_EN
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
`endif
    end
  end

  assign oREADY    = ready_q;
  assign oAUD_BCK  = bck_q;
  assign oAUD_LRCK = lrck_q;
  assign oAUD_DATA = data_q;
  assign oUNDERRUN = underrun_q;

endmodule

// File: tb/tb_audio_i2s_master_tx.sv
// tb/tb_audio_i2s_master_tx.sv - scoreboard bench for audio_i2s_master_tx (16- and 24-bit slot instances)
module tb_audio_i2s_master_tx;

  localparam int BCK_DIV = 2;
  localparam int SW0     = 16;
  localparam int SW1     = 24;
  localparam int FRAME0  = 4 * SW0 * BCK_DIV;
  localparam int FRAME1  = 4 * SW1 * BCK_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        en0 = 1'b0, valid0 = 1'b0, clr0 = 1'b0;
  logic [15:0] l0 = '0, r0 = '0;
  logic        ready0, bck0, lrck0, data0, und0;
  logic        en1 = 1'b0, valid1 = 1'b0, clr1 = 1'b0;
  logic [15:0] l1 = '0, r1 = '0;
  logic        ready1, bck1, lrck1, data1, und1;

  audio_i2s_master_tx #(.DATA_W(16), .SLOT_W(SW0), .BCK_DIV(BCK_DIV)) dut0 (
    .iCLK(clk), .iRST_N(rst_n), .iENABLE(en0), .iSAMPLE_L(l0), .iSAMPLE_R(r0),
    .iVALID(valid0), .oREADY(ready0), .oAUD_BCK(bck0), .oAUD_LRCK(lrck0),
    .oAUD_DATA(data0), .oUNDERRUN(und0), .iCLR_UNDERRUN(clr0));

  audio_i2s_master_tx #(.DATA_W(16), .SLOT_W(SW1), .BCK_DIV(BCK_DIV)) dut1 (
    .iCLK(clk), .iRST_N(rst_n), .iENABLE(en1), .iSAMPLE_L(l1), .iSAMPLE_R(r1),
    .iVALID(valid1), .oREADY(ready1), .oAUD_BCK(bck1), .oAUD_LRCK(lrck1),
    .oAUD_DATA(data1), .oUNDERRUN(und1), .iCLR_UNDERRUN(clr1));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] rxq0[$], rxq1[$], expq0[$], expq1[$];
  int          hlq0[$], hlq1[$];
  logic [15:0] last_l = '0, last_r = '0;

  int          phase[2];
  int          cnt[2];
  logic [63:0] acc[2];
  logic        pb[2], pl[2], pd[2];
  int          hl_start[2];

  function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r, input int sw);
    logic [63:0] f;
    if (sw == 16) f = {32'h0, l, r};
    else          f = {16'h0, l, 8'h00, r, 8'h00};
    return f;
  endfunction

  // Bit capture at every BCK rise; frames are assembled from LRCK=1 slot then LRCK=0 slot.
  task automatic mon_step(input int k, input logic b, input logic l, input logic d, input int sw);
    if (!rst_n) begin
      phase[k] = 0; cnt[k] = 0; acc[k] = '0;
      pb[k] = 1'b0; pl[k] = 1'b0; pd[k] = 1'b0;
    end else begin
      if (b && !pb[k]) begin
        checks++;
        if (d !== pd[k] || l !== pl[k]) begin
          failures++;
          $display("FAIL stable_at_rise inst=%0d data=%b before=%b lrck=%b before=%b", k, d, pd[k], l, pl[k]);
        end
        if (l) begin
          if (phase[k] != 1) begin phase[k] = 1; cnt[k] = 0; acc[k] = '0; end
          acc[k] = {acc[k][62:0], d};
          cnt[k]++;
        end else if (phase[k] != 0) begin
          phase[k] = 2;
          acc[k] = {acc[k][62:0], d};
          cnt[k]++;
          if (cnt[k] == 2 * sw) begin
            if (k == 0) rxq0.push_back(acc[k]); else rxq1.push_back(acc[k]);
            phase[k] = 0;
          end
        end
      end
      if (l && !pl[k]) hl_start[k] = cyc;
      if (!l && pl[k]) begin
        if (k == 0) hlq0.push_back(cyc - hl_start[k]); else hlq1.push_back(cyc - hl_start[k]);
      end
      pb[k] = b; pl[k] = l; pd[k] = d;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, bck0, lrck0, data0, SW0);
    mon_step(1, bck1, lrck1, data1, SW1);
  end

  task automatic push_pair(input int k, input logic [15:0] l, input logic [15:0] r, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (k == 0) begin valid0 = 1'b1; l0 = l; r0 = r; end
    else        begin valid1 = 1'b1; l1 = l; r1 = r; end
    for (int i = 0; i < 400 && !ok; i++) begin
      if ((k == 0) ? ready0 : ready1) begin @(posedge clk); #1; ok = 1'b1; end
      else @(negedge clk);
    end
    if (k == 0) valid0 = 1'b0; else valid1 = 1'b0;
  endtask

  task automatic wait_lrck_rise(input int k, input int budget, output bit ok);
    logic prev, cur;
    ok = 1'b0;
    prev = (k == 0) ? lrck0 : lrck1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      cur = (k == 0) ? lrck0 : lrck1;
      if (cur && !prev) ok = 1'b1;
      prev = cur;
    end
  endtask

  task automatic wait_rx(input int k, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (((k == 0) ? rxq0.size() : rxq1.size()) >= n) ok = 1'b1;
    end
  endtask

  task automatic track_last_fall(input int k, input int ncyc, output int t_last);
    logic prev, cur;
    t_last = -1;
    prev = (k == 0) ? bck0 : bck1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      cur = (k == 0) ? bck0 : bck1;
      if (prev && !cur) t_last = cyc;
      prev = cur;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({bck0, lrck0, data0, ready0, und0} !== 5'b00010) begin
      failures++; $display("FAIL reset_values got=%b exp=00010", {bck0, lrck0, data0, ready0, und0});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bck0, lrck0, data0, ready0, und0} !== 5'b00010) begin
      failures++; $display("FAIL after_release got=%b exp=00010", {bck0, lrck0, data0, ready0, und0});
    end
  endtask

  task automatic test_single_frame;
    bit ok;
    int n;
    logic [63:0] got, exp;
    hlq0.delete();
    push_pair(0, 16'hA5F0, 16'h0F0F, ok);
    expq0.push_back(exp_frame(16'hA5F0, 16'h0F0F, SW0));
    last_l = 16'hA5F0; last_r = 16'h0F0F;
    @(negedge clk);
    checks++;
    if (!ok || ready0 !== 1'b0) begin failures++; $display("FAIL accept_ready ok=%0d ready=%b exp=0", ok, ready0); end
    en0 = 1'b1;
    wait_lrck_rise(0, 50, ok);
    checks++;
    if (!ok || ready0 !== 1'b1) begin failures++; $display("FAIL start_load ok=%0d ready=%b exp=1", ok, ready0); end
    n = 0;
    while (bck0 == 1'b0 && n < 20) begin @(negedge clk); n++; end
    en0 = 1'b0;
    checks++;
    if (n != BCK_DIV) begin failures++; $display("FAIL first_bck_rise got=%0d exp=%0d", n, BCK_DIV); end
    wait_rx(0, 1, FRAME0 + 50, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL single_frame_timeout got=0 exp=1 frame");
    end else begin
      got = rxq0.pop_front(); exp = expq0.pop_front();
      if (got !== exp) begin failures++; $display("FAIL single_frame got=%h exp=%h", got, exp); end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (hlq0.size() < 1 || hlq0[0] != 2 * SW0 * BCK_DIV) begin
      failures++; $display("FAIL lrck_high_len got=%0d exp=%0d", (hlq0.size() > 0) ? hlq0[0] : -1, 2 * SW0 * BCK_DIV);
    end
    checks++;
    if ({bck0, lrck0, data0, und0} !== 4'b0000) begin
      failures++; $display("FAIL idle_after_frame got=%b exp=0000", {bck0, lrck0, data0, und0});
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] src_l[3], src_r[3];
    logic [63:0] got, exp;
    int idx, acc_n, acc_at1, acc_at2, first_i;
    logic rdy_prev, vld_prev, lr_prev, rdy_at1;
    bit started;
    src_l[0] = 16'h1234; src_r[0] = 16'hFEDC;
    src_l[1] = 16'h8001; src_r[1] = 16'h7FFE;
    src_l[2] = 16'hC3A5; src_r[2] = 16'h5A3C;
    for (int j = 0; j < 3; j++) expq0.push_back(exp_frame(src_l[j], src_r[j], SW0));
    idx = 0; acc_n = 0; acc_at1 = -1; acc_at2 = -1; first_i = -1;
    rdy_prev = 1'b0; vld_prev = 1'b0; lr_prev = lrck0; rdy_at1 = 1'bx; started = 1'b0;
    for (int i = 0; i < 3000 && rxq0.size() < 3; i++) begin
      @(negedge clk);
      if (vld_prev && rdy_prev) begin
        acc_n++; idx++;
        if (first_i < 0) first_i = i;
      end
      if (idx < 3) begin valid0 = 1'b1; l0 = src_l[idx]; r0 = src_r[idx]; end
      else valid0 = 1'b0;
      if (acc_n >= 1 && !started) begin en0 = 1'b1; started = 1'b1; end
      if (rxq0.size() == 1 && acc_at1 < 0) begin acc_at1 = acc_n; rdy_at1 = ready0; end
      if (rxq0.size() == 2 && acc_at2 < 0) acc_at2 = acc_n;
      if (rxq0.size() == 2 && lrck0 && !lr_prev) en0 = 1'b0;
      lr_prev = lrck0; vld_prev = valid0; rdy_prev = ready0;
    end
    valid0 = 1'b0; en0 = 1'b0;
    last_l = src_l[2]; last_r = src_r[2];
    checks++;
    if (first_i != 1) begin failures++; $display("FAIL first_accept_cycle got=%0d exp=1", first_i); end
    checks++;
    if (acc_at1 != 2 || rdy_at1 !== 1'b0) begin
      failures++; $display("FAIL backpressure_f1 accepted=%0d ready=%b exp=2,0", acc_at1, rdy_at1);
    end
    checks++;
    if (acc_at2 != 3) begin failures++; $display("FAIL backpressure_f2 accepted=%0d exp=3", acc_at2); end
    for (int j = 0; j < 3; j++) begin
      exp = expq0.pop_front();
      checks++;
      if (rxq0.size() == 0) begin
        failures++; $display("FAIL b2b_frame%0d got=none exp=%h", j, exp);
      end else begin
        got = rxq0.pop_front();
        if (got !== exp) begin failures++; $display("FAIL b2b_frame%0d got=%h exp=%h", j, got, exp); end
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (und0 !== 1'b0) begin failures++; $display("FAIL b2b_no_underrun got=%b exp=0", und0); end
  endtask

  task automatic test_underrun;
    bit ok;
    logic [63:0] got, exp;
`ifdef AUD_TX_REPEAT_ON_UNDERRUN_EN
    exp = exp_frame(last_l, last_r, SW0);
`else
    exp = 64'h0;
`endif
    expq0.push_back(exp); expq0.push_back(exp);
    en0 = 1'b1;
    wait_lrck_rise(0, 50, ok);
    checks++;
    if (!ok || und0 !== 1'b1) begin failures++; $display("FAIL underrun_set ok=%0d got=%b exp=1", ok, und0); end
    repeat (10) @(negedge clk);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    checks++;
    if (und0 !== 1'b0) begin failures++; $display("FAIL underrun_clear got=%b exp=0", und0); end
    clr0 = 1'b1;
    wait_lrck_rise(0, FRAME0 + 20, ok);
    checks++;
    if (!ok || und0 !== 1'b1) begin failures++; $display("FAIL set_beats_clear ok=%0d got=%b exp=1", ok, und0); end
    @(negedge clk);
    en0 = 1'b0;
    checks++;
    if (und0 !== 1'b0) begin failures++; $display("FAIL clear_held got=%b exp=0", und0); end
    clr0 = 1'b0;
    wait_rx(0, 2, 2 * FRAME0 + 50, ok);
    for (int j = 0; j < 2; j++) begin
      exp = expq0.pop_front();
      checks++;
      if (rxq0.size() == 0) begin
        failures++; $display("FAIL underrun_frame%0d got=none exp=%h", j, exp);
      end else begin
        got = rxq0.pop_front();
        if (got !== exp) begin failures++; $display("FAIL underrun_frame%0d got=%h exp=%h", j, got, exp); end
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_disable_midframe;
    bit ok;
    int t0, t1, falls;
    logic prev;
    logic [63:0] got, exp;
    push_pair(0, 16'h1357, 16'hBDF0, ok);
    expq0.push_back(exp_frame(16'h1357, 16'hBDF0, SW0));
    last_l = 16'h1357; last_r = 16'hBDF0;
    en0 = 1'b1;
    wait_lrck_rise(0, 50, ok);
    t0 = cyc;
    falls = 0; prev = bck0;
    for (int i = 0; i < 200 && falls < 5; i++) begin
      @(negedge clk);
      if (prev && !bck0) falls++;
      prev = bck0;
    end
    en0 = 1'b0;
    track_last_fall(0, FRAME0 + 60, t1);
    checks++;
    if (t1 - t0 != FRAME0) begin failures++; $display("FAIL disable_frame_len got=%0d exp=%0d", t1 - t0, FRAME0); end
    checks++;
    if ({bck0, lrck0, data0} !== 3'b000) begin
      failures++; $display("FAIL disable_idle got=%b exp=000", {bck0, lrck0, data0});
    end
    exp = expq0.pop_front();
    checks++;
    if (rxq0.size() == 0) begin
      failures++; $display("FAIL disable_frame got=none exp=%h", exp);
    end else begin
      got = rxq0.pop_front();
      if (got !== exp) begin failures++; $display("FAIL disable_frame got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_slot24;
    bit ok;
    int t0, t1;
    logic [63:0] got, exp;
    hlq1.delete();
    push_pair(1, 16'hBEEF, 16'h0DD1, ok);
    expq1.push_back(exp_frame(16'hBEEF, 16'h0DD1, SW1));
    en1 = 1'b1;
    wait_lrck_rise(1, 50, ok);
    t0 = cyc;
    en1 = 1'b0;
    track_last_fall(1, FRAME1 + 60, t1);
    checks++;
    if (t1 - t0 != FRAME1) begin failures++; $display("FAIL slot24_frame_len got=%0d exp=%0d", t1 - t0, FRAME1); end
    checks++;
    if (hlq1.size() < 1 || hlq1[0] != 2 * SW1 * BCK_DIV) begin
      failures++; $display("FAIL slot24_lrck_high got=%0d exp=%0d", (hlq1.size() > 0) ? hlq1[0] : -1, 2 * SW1 * BCK_DIV);
    end
    exp = expq1.pop_front();
    checks++;
    if (rxq1.size() == 0) begin
      failures++; $display("FAIL slot24_frame got=none exp=%h", exp);
    end else begin
      got = rxq1.pop_front();
      if (got !== exp) begin failures++; $display("FAIL slot24_frame got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_reset_midrun;
    bit ok;
    logic [63:0] got, exp;
    en0 = 1'b1;
    wait_lrck_rise(0, 50, ok);
    push_pair(0, 16'h4242, 16'h2424, ok);
    repeat (12) @(negedge clk);
    checks++;
    if ({lrck0, ready0, und0} !== 3'b101) begin
      failures++; $display("FAIL pre_reset got=%b exp=101", {lrck0, ready0, und0});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bck0, lrck0, data0, ready0, und0} !== 5'b00010) begin
      failures++; $display("FAIL async_reset got=%b exp=00010", {bck0, lrck0, data0, ready0, und0});
    end
    en0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready0 !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", ready0); end
    expq0.push_back(64'h0);
    en0 = 1'b1;
    wait_lrck_rise(0, 50, ok);
    en0 = 1'b0;
    checks++;
    if (!ok || und0 !== 1'b1) begin failures++; $display("FAIL holding_discarded ok=%0d und=%b exp=1", ok, und0); end
    wait_rx(0, 1, FRAME0 + 50, ok);
    exp = expq0.pop_front();
    checks++;
    if (!ok) begin
      failures++; $display("FAIL post_reset_frame got=none exp=%h", exp);
    end else begin
      got = rxq0.pop_front();
      if (got !== exp) begin failures++; $display("FAIL post_reset_frame got=%h exp=%h", got, exp); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_disable_midframe();
    test_slot24();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
